pipeline_arb: RTL and testbench
===============================

# pipeline_arb

Credit-based round-robin arbiter that shares the single input port of the filter/buffer pipeline among `NUM_REQ` requesters. It sits directly upstream of the pipeline top and drives its data and valid inputs. It tracks free buffer slots with a credit counter, so the pipeline is never pushed beyond what its output buffer can hold. The buffer stage itself has no backpressure; this block supplies it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 32: payload width; matches the pipeline data width.
- `CREDITS`, 8: initial and maximum credits; set equal to the pipeline buffer depth.
- `MAX_BURST`, 4: beats per grant; used only with `PIPE_ARB_BURST_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot or zero; combinational grant.
- `pipe_data`  out  DATA_WIDTH  registered payload to the pipeline `data_in`.
- `pipe_valid`  out  1  registered strobe to the pipeline `valid_in`.
- `credit_return`  in  1  one pulse per word popped from the pipeline buffer (read_en && !empty).
- `grant_id`  out  $clog2(NUM_REQ)  requester of the last accepted beat.
- `credits_avail`  out  $clog2(CREDITS+1)  current credit count.
- `err_credit`  out  1  sticky; set when a credit is returned while the count is already CREDITS.

## Operation
- A transfer (accept) occurs when `req_valid[i] && req_ready[i]`.
  - At most one accept per cycle.
  - Each accept consumes one credit.
- `req_ready[i]` is asserted only when all of the following hold:
  - i is the arbitration winner;
  - `req_valid[i]` is high;
  - `credits_avail > 0`;
  - `rst` is low.
- Round-robin selection:
  - The priority pointer `ptr` resets to 0.
  - The winner is the first valid requester scanning from `ptr` upward, wrapping modulo NUM_REQ.
  - After an accept from requester i, `ptr` becomes (i+1) mod NUM_REQ.
- Credit counter:
  - Accept only: count decrements.
  - `credit_return` only: count increments.
  - Both in the same cycle: count unchanged.
  - Return while count == CREDITS: count holds at CREDITS and `err_credit` sets.
  - The count never underflows, because `req_ready` is gated on count > 0.
- FSM states:
  - IDLE: no valid requester.
  - ACTIVE: accepts are occurring.
  - STALL: at least one valid requester but credits == 0.
- FSM transitions:
  - IDLE→ACTIVE on any valid with credits > 0.
  - ACTIVE→STALL when the count reaches 0 while valids remain.
  - STALL→ACTIVE on a `credit_return`.
  - Any state→IDLE when no valid is asserted.
  - The state is visible only through `req_ready` behaviour; there is no state port.

## Timing
- Latency: an accept in cycle N produces `pipe_valid=1` in cycle N+1, with `pipe_data` equal to the accepted payload.
- `pipe_valid` is low in any cycle that follows a cycle without an accept.
- `pipe_data` holds its last value when `pipe_valid` is low.
- `credits_avail` and `grant_id` are registered; both reflect the accept and the return one cycle later.
- Reset values:
  - `pipe_valid`=0, `pipe_data`=0, `grant_id`=0.
  - `credits_avail`=CREDITS, `err_credit`=0.
  - `ptr`=0, state IDLE.
  - `req_ready`=0 while `rst` is high.
- Reset mid-burst or mid-stall: all state returns to the reset values on the next edge. Credits are restored to CREDITS, so the pipeline must be reset in the same cycle.
- A requester may drop `req_valid` at any time; no beat is taken without `req_ready` high.

## Configuration
- Macro: `PIPE_ARB_BURST_EN`.
- Defined:
  - The winner keeps the grant for up to MAX_BURST consecutive beats while its `req_valid` stays high and credits remain.
  - The beat counter resets on grant change.
  - `ptr` advances at the end of the burst.
  - When credits run out mid-burst, the beat count is kept and the burst resumes after a return.
- Undefined: re-arbitration every cycle; `MAX_BURST` is ignored.

## Structure
- Shared `pipeline_pkg` holds:
  - `arb_state_e` (IDLE, ACTIVE, STALL);
  - the typedefs `req_id_t` and `credit_t`;
  - the default `CREDITS` constant, shared with the buffer depth.
- Sub-module `rr_picker`:
  - combinational;
  - inputs: request vector and pointer;
  - outputs: one-hot winner and encoded index.
- Counter, FSM and output registers live in `pipeline_arb`.

## Test plan
- Reset, then requesters 0–3 all valid with ample returns → accepts in order 0,1,2,3,0 on consecutive cycles; `pipe_valid` stays high from cycle 2.
- No returns, CREDITS=8, requester 1 always valid → exactly 8 accepts, then `req_ready`=0 and `credits_avail`=0. One return → exactly one more accept.
- Accept and `credit_return` in the same cycle with count=3 → count stays at 3.
- `credit_return` at count=8 → count stays at 8 and `err_credit`=1 until reset.
- With `PIPE_ARB_BURST_EN`, MAX_BURST=4, requesters 0 and 2 valid → grants 0,0,0,0,2,2,2,2,0.
- `rst` asserted mid-stream with count=2 → next cycle `pipe_valid`=0, `credits_avail`=8, `ptr`=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the filter/buffer pipeline and its input arbiter.
package pipeline_pkg;

  localparam int DEF_CREDITS = 8;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    STALL
  } arb_state_e;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0]   req_id_t;
  typedef logic [$clog2(DEF_CREDITS+1)-1:0] credit_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pipeline_arb.sv
// Credit-based round-robin arbiter feeding the pipeline input port.
// Optional burst grants are enabled by defining PIPE_ARB_BURST_EN.
module pipeline_arb
  import pipeline_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = DEF_CREDITS,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           pipe_data,
  output logic                            pipe_valid,
  input  logic                            credit_return,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [$clog2(CREDITS+1)-1:0]    credits_avail,
  output logic                            err_credit
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CREDITS+1);

  // Handshake: a beat moves when req_valid[i] && req_ready[i]; ready is never
  // a precondition for valid, and a requester may drop valid at any time.

  logic [IW-1:0]         ptr;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         win_idx;
  logic [IW-1:0]         ptr_next;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CW-1:0]         credits_next;
  logic                  any_valid;
  logic                  accept;
  logic                  cred_zero;
  logic                  cred_full;
  logic                  err_set;
  arb_state_e            state;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_onehot),
    .idx   (pick_idx)
  );

`ifdef PIPE_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST+1);

  logic          locked;
  logic [IW-1:0] lock_id;
  logic [BW-1:0] beat_cnt;
  logic          lock_hold;

  // The burst owner keeps the grant only while it is still requesting.
  assign lock_hold = locked && req_valid[lock_id];

  always_comb begin
    win_idx    = pick_idx;
    win_onehot = pick_onehot;
    if (lock_hold) begin
      win_idx             = lock_id;
      win_onehot          = '0;
      win_onehot[lock_id] = 1'b1;
    end
  end
`else
  assign win_idx    = pick_idx;
  assign win_onehot = pick_onehot;
`endif

  assign any_valid = |req_valid;
  assign cred_zero = (credits_avail == '0);
  assign cred_full = (credits_avail == CW'(CREDITS));
  assign req_ready = (!rst && !cred_zero) ? win_onehot : '0;
  assign accept    = |(req_ready & req_valid);
  assign ptr_next  = (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + IW'(1);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A return in the same cycle as an accept cancels out, even at full count.
  always_comb begin
    credits_next = credits_avail;
    err_set      = 1'b0;
    if (accept && !credit_return) begin
      credits_next = credits_avail - CW'(1);
    end else if (!accept && credit_return) begin
      if (cred_full) err_set = 1'b1;
      else           credits_next = credits_avail + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid    <= 1'b0;
      pipe_data     <= '0;
      grant_id      <= '0;
      credits_avail <= CW'(CREDITS);
      err_credit    <= 1'b0;
      ptr           <= '0;
      state         <= IDLE;
`ifdef PIPE_ARB_BURST_EN
      locked        <= 1'b0;
      lock_id       <= '0;
      beat_cnt      <= '0;
`endif
    end else begin
      pipe_valid    <= accept;
      credits_avail <= credits_next;
      if (err_set) err_credit <= 1'b1;
      if (accept) begin
        pipe_data <= sel_data;
        grant_id  <= win_idx;
        ptr       <= ptr_next;
      end

      case (state)
        IDLE: begin
          if (any_valid) state <= cred_zero ? STALL : ACTIVE;
        end
        ACTIVE: begin
          if (!any_valid)               state <= IDLE;
          else if (credits_next == '0)  state <= STALL;
        end
        STALL: begin
          if (!any_valid)         state <= IDLE;
          else if (credit_return) state <= ACTIVE;
        end
        default: state <= IDLE;
      endcase

`ifdef PIPE_ARB_BURST_EN
      if (accept) begin
        if (lock_hold) begin
          beat_cnt <= beat_cnt + BW'(1);
          locked   <= (beat_cnt + BW'(1)) < BW'(MAX_BURST);
        end else begin
          beat_cnt <= BW'(1);
          lock_id  <= win_idx;
          locked   <= (MAX_BURST > 1);
        end
      end else if (!lock_hold) begin
        locked <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pipeline_arb.sv
// Directed and random checks for pipeline_arb against a small reference model.
module tb_pipeline_arb;
  import pipeline_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CR = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     pipe_data;
  logic              pipe_valid;
  logic              credit_return;
  req_id_t           grant_id;
  credit_t           credits_avail;
  logic              err_credit;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  int            acc_ids[$];

  int            m_ptr;
  int            m_cred;
  logic          m_err;
  int            m_last_id;
  logic [DW-1:0] m_last_data;
  logic          m_lock;
  int            m_lock_id;
  int            m_beats;

  pipeline_arb #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .CREDITS(CR), .MAX_BURST(MB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .pipe_data     (pipe_data),
    .pipe_valid    (pipe_valid),
    .credit_return (credit_return),
    .grant_id      (grant_id),
    .credits_avail (credits_avail),
    .err_credit    (err_credit)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr       = 0;
    m_cred      = CR;
    m_err       = 1'b0;
    m_last_id   = 0;
    m_last_data = '0;
    m_lock      = 1'b0;
    m_lock_id   = 0;
    m_beats     = 0;
    exp_q.delete();
    acc_ids.delete();
  endtask

  function automatic int model_winner();
`ifdef PIPE_ARB_BURST_EN
    if (m_lock && req_valid[m_lock_id]) return m_lock_id;
`endif
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    req_valid     = '1;
    credit_return = 1'b0;
    #1;
    check("ready_in_rst", req_ready, 0);
    @(posedge clk); #1;
    check("rst_pipe_valid", pipe_valid, 0);
    check("rst_pipe_data", pipe_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_credits", credits_avail, CR);
    check("rst_err", err_credit, 0);
    rst       = 1'b0;
    req_valid = '0;
    model_reset();
  endtask

  task automatic new_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
  endtask

  // driver: one clock cycle with the current req_valid/req_data and a return flag
  task automatic step(input logic ret);
    int            w;
    logic [N-1:0]  exp_ready;
    logic          acc;
    logic [DW-1:0] d;
    credit_return = ret;
    #1;
    if (m_lock && !req_valid[m_lock_id]) m_lock = 1'b0;
    w = model_winner();
    exp_ready = '0;
    if (w >= 0 && m_cred > 0) exp_ready[w] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    acc = (exp_ready != '0);
    if (acc) begin
      d = req_data[w*DW +: DW];
      exp_q.push_back(d);
      acc_ids.push_back(w);
    end
    @(posedge clk); #1;
    credit_return = 1'b0;
    if (acc) begin
      m_ptr     = (w + 1) % N;
      m_last_id = w;
      if (m_lock && w == m_lock_id) m_beats++;
      else begin
        m_lock_id = w;
        m_beats   = 1;
      end
      m_lock = (m_beats < MB);
    end
    if (acc && !ret) m_cred--;
    else if (!acc && ret) begin
      if (m_cred == CR) m_err = 1'b1;
      else              m_cred++;
    end
    check("pipe_valid", pipe_valid, acc);
    if (acc) begin
      d = exp_q.pop_front();
      check("pipe_data", pipe_data, d);
      m_last_data = d;
    end else begin
      check("pipe_hold", pipe_data, m_last_data);
    end
    check("credits_avail", credits_avail, m_cred);
    check("err_credit", err_credit, m_err);
    check("grant_id", grant_id, m_last_id);
  endtask

  initial begin
    int start;
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_b[9]  = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
    rst           = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    credit_return = 1'b0;
    model_reset();

    do_reset();

    // all four requesters with a return every cycle
    req_valid = '1;
    for (int s = 0; s < 5; s++) begin
      new_data();
      step(1'b1);
    end
`ifndef PIPE_ARB_BURST_EN
    for (int s = 0; s < 5; s++) check("rr_order", acc_ids[s], exp_rr[s]);
`endif

    // credit exhaustion with requester 1 only
    req_valid = '0;
    step(1'b0);
    start = acc_ids.size();
    req_valid = 4'b0010;
    for (int s = 0; s < 10; s++) begin
      new_data();
      step(1'b0);
    end
    check("stall_accepts", acc_ids.size() - start, 8);
    check("stall_credits", credits_avail, 0);
    #1;
    check("stall_ready", req_ready, 0);
    step(1'b1);
    new_data();
    step(1'b0);
    step(1'b0);
    check("one_more_accept", acc_ids.size() - start, 9);

    // accept and return in the same cycle at count 3
    req_valid = '0;
    for (int s = 0; s < 3; s++) step(1'b1);
    req_valid = 4'b0100;
    new_data();
    step(1'b1);
    check("same_cycle_cnt", credits_avail, 3);

    // over-return sets the sticky error
    req_valid = '0;
    for (int s = 0; s < 5; s++) step(1'b1);
    check("full_no_err", err_credit, 0);
    step(1'b1);
    check("over_return_err", err_credit, 1);
    check("over_return_cnt", credits_avail, CR);
    step(1'b0);
    step(1'b0);
    check("err_sticky", err_credit, 1);

    // reset mid-stream at count 2
    do_reset();
    req_valid = '1;
    for (int s = 0; s < 6; s++) begin
      new_data();
      step(1'b0);
    end
    check("pre_rst_cnt", credits_avail, 2);
    do_reset();
    req_valid = '1;
    new_data();
    step(1'b0);
    check("ptr_after_rst", acc_ids[0], 0);

    // random traffic
    for (int s = 0; s < 60; s++) begin
      req_valid = N'($urandom_range(0, 15));
      new_data();
      step((m_cred < CR) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

`ifdef PIPE_ARB_BURST_EN
    do_reset();
    req_valid = 4'b0101;
    for (int s = 0; s < 9; s++) begin
      new_data();
      step(1'b1);
    end
    for (int s = 0; s < 9; s++) check("burst_order", acc_ids[s], exp_b[s]);
`endif

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
